multi_ch_clk_gate_ctrl: RTL and testbench
=========================================

Name: multi_ch_clk_gate_ctrl

Overview:
- Parametrised, multi-channel clock-gating controller for the MCU system.
- Per channel: software enable, automatic idle-timeout gating, and activity/request-driven wake with a four-phase wake handshake.
- Each channel drives one glitch-free gated clock through a latch-based gate cell; TESTMODE forces every gated clock to run.
- Sits between the system clock root and peripheral clock domains (timers, UART, GPIO banks).

Parameters:
- NUM_CH, 4, number of gated clock channels (1..16).
- IDLE_CNT_W, 8, width of the idle counter and of IDLE_LIMIT.
- WAKE_DELAY, 2, cycles the clock runs in WAKE before CH_WAKE_ACK may assert (1..15).

Ports:
- HCLK  input  1  system clock; the only clock.
- HRESETn  input  1  asynchronous active-low reset.
- TESTMODE  input  1  forces all gate enables high (scan/test); FSMs unaffected.
- CH_ENABLE  input  NUM_CH  per-channel software enable.
- CH_ACTIVE  input  NUM_CH  per-channel activity indication from the peripheral (HCLK domain).
- IDLE_LIMIT  input  IDLE_CNT_W  idle cycles before auto-gating, shared by all channels; 0 disables auto-gating.
- CH_WAKE_REQ  input  NUM_CH  per-channel level wake request.
- CH_WAKE_ACK  output  NUM_CH  per-channel wake acknowledge (registered).
- CH_GATED  output  NUM_CH  per-channel status, 1 = clock stopped (registered).
- GCLK  output  NUM_CH  per-channel gated clocks.

Behaviour:
- Reset (async, HRESETn=0):
  - All channel states = OFF, clken_q=0, idle_cnt=0, wake_cnt=0.
  - CH_WAKE_ACK=0, CH_GATED=all ones.
  - GCLK low unless TESTMODE=1.
- Gate timing:
  - clken_q is registered on the HCLK rising edge.
  - Gate latch is transparent while HCLK is low; GCLK = HCLK & latch.
  - clken_q rising at edge N gives the first GCLK high phase at edge N+1.
  - clken_q falling at edge N gives no GCLK pulse from edge N+1 onward.
  - No GCLK glitch or truncated pulse under any input timing.
- Per-channel FSM (states OFF, WAKE, RUN, GATED), evaluated every HCLK rising edge:
  - OFF: clken_q=0, CH_GATED=1. Goes to WAKE when CH_ENABLE=1.
  - WAKE: clken_q=1, CH_GATED=0. wake_cnt counts 0..WAKE_DELAY-1, then the FSM goes to RUN with idle_cnt=0.
  - RUN: clken_q=1, CH_GATED=0.
    - idle_cnt increments on each cycle with CH_ACTIVE=0 and CH_WAKE_REQ=0.
    - idle_cnt clears on any cycle with CH_ACTIVE=1 or CH_WAKE_REQ=1.
    - When idle_cnt reaches IDLE_LIMIT (IDLE_LIMIT != 0), go to GATED: exactly IDLE_LIMIT consecutive idle cycles before the gated edge.
  - GATED: clken_q=0, CH_GATED=1. Goes to WAKE on CH_ACTIVE=1 or CH_WAKE_REQ=1.
  - Any state with CH_ENABLE=0: go to OFF next edge. This has priority over all other transitions, including mid-WAKE; wake_cnt and idle_cnt clear.
- Wake handshake (four-phase):
  - CH_WAKE_ACK is set the cycle after state=RUN and CH_WAKE_REQ=1.
  - CH_WAKE_ACK is cleared the cycle after CH_WAKE_REQ=0, or on entry to OFF.
  - While CH_WAKE_REQ=1 the channel never auto-gates.
  - CH_WAKE_REQ dropping before ACK aborts the request. WAKE still completes, and the channel runs the normal idle timeout.
- IDLE_LIMIT:
  - Sampled every cycle.
  - Lowering it below the current idle_cnt gates the channel on the next edge (comparison is idle_cnt >= IDLE_LIMIT).
  - idle_cnt saturates at all ones.
- Channels are fully independent; simultaneous events on different channels do not interact.
- TESTMODE=1: gate enable = clken_q | TESTMODE. CH_GATED reports FSM state, not the actual clock.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: OFF=2'b00, WAKE=2'b01, RUN=2'b10, GATED=2'b11.
  - Parameter range checks.
- One sub-module, clk_gate_cell (CLK, CLKEN, TESTMODE → CLKOUT, latch-based), instantiated NUM_CH times in a generate loop. It is replaced by the library ICG cell in synthesis.
- Per-channel FSM and counters live inline in the generate loop.

Test Plan:
- Reset with CH_ENABLE=4'b0001, WAKE_DELAY=2 → state WAKE at edge 1. GCLK[0] first high at edge 2. RUN at edge 3. CH_GATED=4'b1110.
- IDLE_LIMIT=8, CH_ACTIVE[0]=0 after RUN → clken_q[0] falls exactly 8 edges later. No GCLK[0] pulse after the following edge. CH_GATED[0]=1.
- GATED channel, CH_WAKE_REQ[1]=1 → WAKE, then RUN after 2 cycles. CH_WAKE_ACK[1]=1 one cycle later. Hold REQ for 50 cycles with IDLE_LIMIT=4 → no gating. REQ=0 → ACK=0 next cycle; gated 4 cycles after that.
- CH_ENABLE[2] dropped during WAKE (wake_cnt=1) → OFF next edge. ACK stays 0. GCLK[2] stops cleanly with no runt pulse (checked with a glitch monitor on every GCLK).
- IDLE_LIMIT=0 with all channels idle for 300 cycles → no channel gates. Then set IDLE_LIMIT=5 with idle_cnt saturated at 255 → all running channels gate on the next edge.
- TESTMODE=1 with all channels OFF → GCLK equals HCLK on all 4 outputs while CH_GATED stays 4'b1111. Async HRESETn assertion mid-RUN → outputs return to reset values immediately.

Source files
------------

// File: rtl/multi_ch_clk_gate_ctrl_pkg.sv
// Shared types and parameter checks for the multi-channel clock-gating controller.
package multi_ch_clk_gate_ctrl_pkg;

  // Per-channel FSM encoding
  typedef enum logic [1:0] {
    StOff   = 2'b00,
    StWake  = 2'b01,
    StRun   = 2'b10,
    StGated = 2'b11
  } ch_state_e;

  localparam int unsigned MaxNumCh     = 16;
  localparam int unsigned MaxWakeDelay = 15;
  localparam int unsigned MaxIdleCntW  = 32;
  // Wide enough to hold MaxWakeDelay - 1
  localparam int unsigned WakeCntW     = 4;

  // True when the instance parameters are within their supported ranges
  function automatic bit params_ok(input int unsigned num_ch,
                                   input int unsigned idle_cnt_w,
                                   input int unsigned wake_delay);
    return (num_ch >= 1) && (num_ch <= MaxNumCh) &&
           (idle_cnt_w >= 1) && (idle_cnt_w <= MaxIdleCntW) &&
           (wake_delay >= 1) && (wake_delay <= MaxWakeDelay);
  endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Latch-based glitch-free clock gate; stands in for the library ICG cell.
module clk_gate_cell (
  input  logic CLK,
  input  logic CLKEN,
  input  logic TESTMODE,
  output logic CLKOUT
);

  logic en_l;

  // Enable is captured only while CLK is low, so it cannot change during a high phase
  always_latch begin
    if (!CLK) en_l <= CLKEN | TESTMODE;
  end

  assign CLKOUT = CLK & en_l;

endmodule

// File: rtl/multi_ch_clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel enable, idle auto-gating and
// request-driven wake with a four-phase acknowledge.
module multi_ch_clk_gate_ctrl
  import multi_ch_clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned IDLE_CNT_W = 8,
  parameter int unsigned WAKE_DELAY = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  TESTMODE,
  input  logic [NUM_CH-1:0]     CH_ENABLE,
  input  logic [NUM_CH-1:0]     CH_ACTIVE,
  input  logic [IDLE_CNT_W-1:0] IDLE_LIMIT,
  input  logic [NUM_CH-1:0]     CH_WAKE_REQ,
  output logic [NUM_CH-1:0]     CH_WAKE_ACK,
  output logic [NUM_CH-1:0]     CH_GATED,
  output logic [NUM_CH-1:0]     GCLK
);

  if (!params_ok(NUM_CH, IDLE_CNT_W, WAKE_DELAY)) begin : g_param_err
    $error("multi_ch_clk_gate_ctrl: parameter out of range");
  end

  localparam logic [WakeCntW-1:0] WakeLast = WakeCntW'(WAKE_DELAY - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e             state_q, state_d;
    logic [WakeCntW-1:0]   wake_cnt_q, wake_cnt_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [IDLE_CNT_W-1:0] idle_inc;
    logic                  clken_q, clken_d;
    logic                  gated_q, gated_d;
    logic                  ack_q, ack_d;
    logic                  busy;

    assign busy     = CH_ACTIVE[i] | CH_WAKE_REQ[i];
    // Saturating increment so a long idle stretch never wraps back below the limit
    assign idle_inc = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + IDLE_CNT_W'(1);

    // State and registered outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        state_q    <= StOff;
        wake_cnt_q <= '0;
        idle_cnt_q <= '0;
        clken_q    <= 1'b0;
        gated_q    <= 1'b1;
        ack_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        wake_cnt_q <= wake_cnt_d;
        idle_cnt_q <= idle_cnt_d;
        clken_q    <= clken_d;
        gated_q    <= gated_d;
        ack_q      <= ack_d;
      end
    end

    // Next state and counters; a dropped enable overrides everything
    always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      idle_cnt_d = idle_cnt_q;
      if (!CH_ENABLE[i]) begin
        state_d    = StOff;
        wake_cnt_d = '0;
        idle_cnt_d = '0;
      end else begin
        unique case (state_q)
          StOff: begin
            state_d    = StWake;
            wake_cnt_d = '0;
          end
          StWake: begin
            if (wake_cnt_q == WakeLast) begin
              state_d    = StRun;
              wake_cnt_d = '0;
              idle_cnt_d = '0;
            end else begin
              wake_cnt_d = wake_cnt_q + WakeCntW'(1);
            end
          end
          StRun: begin
            if (busy) begin
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_inc;
              // Gate on the edge that samples the IDLE_LIMIT-th idle cycle
              if ((IDLE_LIMIT != '0) && (idle_inc >= IDLE_LIMIT)) state_d = StGated;
            end
          end
          StGated: begin
            if (busy) begin
              state_d    = StWake;
              wake_cnt_d = '0;
              idle_cnt_d = '0;
            end
          end
        endcase
      end
    end

    // Registered outputs derived from the next state
    always_comb begin
      clken_d = (state_d == StWake) || (state_d == StRun);
      gated_d = !clken_d;
      ack_d   = ack_q;
      if ((state_d == StOff) || !CH_WAKE_REQ[i]) begin
        ack_d = 1'b0;
      end else if (state_q == StRun) begin
        ack_d = 1'b1;
      end
    end

    assign CH_WAKE_ACK[i] = ack_q;
    assign CH_GATED[i]    = gated_q;

    clk_gate_cell u_cg (
      .CLK      (HCLK),
      .CLKEN    (clken_q),
      .TESTMODE (TESTMODE),
      .CLKOUT   (GCLK[i])
    );
  end

endmodule

// File: tb/tb_multi_ch_clk_gate_ctrl.sv
// Directed bench for multi_ch_clk_gate_ctrl with a scoreboard queue and GCLK glitch monitor.
module tb_multi_ch_clk_gate_ctrl;
  import multi_ch_clk_gate_ctrl_pkg::*;

  logic       HCLK;
  logic       HRESETn;
  logic       TESTMODE;
  logic [3:0] CH_ENABLE;
  logic [3:0] CH_ACTIVE;
  logic [7:0] IDLE_LIMIT;
  logic [3:0] CH_WAKE_REQ;
  logic [3:0] CH_WAKE_ACK;
  logic [3:0] CH_GATED;
  logic [3:0] GCLK;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  multi_ch_clk_gate_ctrl #(
    .NUM_CH     (4),
    .IDLE_CNT_W (8),
    .WAKE_DELAY (2)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .TESTMODE    (TESTMODE),
    .CH_ENABLE   (CH_ENABLE),
    .CH_ACTIVE   (CH_ACTIVE),
    .IDLE_LIMIT  (IDLE_LIMIT),
    .CH_WAKE_REQ (CH_WAKE_REQ),
    .CH_WAKE_ACK (CH_WAKE_ACK),
    .CH_GATED    (CH_GATED),
    .GCLK        (GCLK)
  );

  // Period 10: rising edges at 5 mod 10, falling edges at 0 mod 10
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // A clean gated clock only ever changes together with HCLK in the same direction
  for (genvar g = 0; g < 4; g++) begin : g_mon
    always @(posedge GCLK[g]) begin
      n_cmp++;
      assert ((($time % 10) == 5) && (HCLK === 1'b1)) else begin
        n_mis++;
        $error("FAIL gclk%0d_rise observed=t%0d required=on HCLK rising edge", g, $time);
      end
    end
    always @(negedge GCLK[g]) begin
      n_cmp++;
      assert ((($time % 10) == 0) && (HCLK === 1'b0)) else begin
        n_mis++;
        $error("FAIL gclk%0d_fall observed=t%0d required=on HCLK falling edge", g, $time);
      end
    end
  end

  task automatic expect_val(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_mis++;
      $error("FAIL sb_underflow observed=%h required=a queued expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_mis++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    logic ok;
    HRESETn     = 1'b0;
    TESTMODE    = 1'b0;
    CH_ENABLE   = 4'b0001;
    CH_ACTIVE   = 4'b0000;
    CH_WAKE_REQ = 4'b0000;
    IDLE_LIMIT  = 8'd8;
    #12;
    expect_val("rst_gated", 32'h0000_000F); check(32'(CH_GATED));
    expect_val("rst_ack",   32'h0);         check(32'(CH_WAKE_ACK));
    expect_val("rst_gclk",  32'h0);         check(32'(GCLK));

    // Power-up of channel 0
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();  // edge 1
    expect_val("e1_state0", 32'(StWake)); check(32'(dut.g_ch[0].state_q));
    expect_val("e1_gated",  32'b1110);    check(32'(CH_GATED));
    expect_val("e1_gclk0",  32'h0);       check(32'(GCLK[0]));
    tick();  // edge 2
    expect_val("e2_gclk0",  32'h1);       check(32'(GCLK[0]));
    tick();  // edge 3
    expect_val("e3_state0", 32'(StRun));  check(32'(dut.g_ch[0].state_q));
    expect_val("e3_gated",  32'b1110);    check(32'(CH_GATED));

    // Idle timeout, IDLE_LIMIT=8: gated exactly 8 edges after RUN
    ok = 1'b1;
    repeat (7) begin
      tick();
      if (CH_GATED[0] !== 1'b0) ok = 1'b0;
    end
    expect_val("idle_hold0", 32'h1); check(32'(ok));
    tick();  // edge 11
    expect_val("idle_gate0", 32'h1); check(32'(CH_GATED[0]));
    expect_val("last_pulse0", 32'h1); check(32'(GCLK[0]));
    tick();  // edge 12
    expect_val("no_pulse0", 32'h0); check(32'(GCLK[0]));

    // Bring channel 1 up and let it gate
    CH_ENABLE = 4'b0011;
    tick(10);
    expect_val("ch1_run", 32'h0); check(32'(CH_GATED[1]));
    tick();
    expect_val("ch1_gated", 32'h1); check(32'(CH_GATED[1]));

    // Wake request on gated channel 1
    CH_WAKE_REQ = 4'b0010;
    tick();
    expect_val("req_wake1", 32'h0); check(32'(CH_GATED[1]));
    IDLE_LIMIT = 8'd4;
    tick(2);
    expect_val("req_run1", 32'(StRun)); check(32'(dut.g_ch[1].state_q));
    expect_val("ack_low1", 32'h0);      check(32'(CH_WAKE_ACK));
    tick();
    expect_val("ack_high1", 32'b0010);  check(32'(CH_WAKE_ACK));
    ok = 1'b1;
    repeat (50) begin
      tick();
      if ((CH_GATED[1] !== 1'b0) || (CH_WAKE_ACK[1] !== 1'b1)) ok = 1'b0;
    end
    expect_val("req_hold1", 32'h1); check(32'(ok));
    CH_WAKE_REQ = 4'b0000;
    tick();
    expect_val("ack_drop1", 32'h0);  check(32'(CH_WAKE_ACK));
    expect_val("post_req1", 32'h0);  check(32'(CH_GATED[1]));
    tick(2);
    expect_val("idle3_ch1", 32'h0);  check(32'(CH_GATED[1]));
    tick();
    expect_val("idle4_ch1", 32'h1);  check(32'(CH_GATED[1]));

    // Enable of channel 2 dropped mid-WAKE
    CH_ENABLE = 4'b0111;
    tick();
    expect_val("ch2_wake", 32'h0); check(32'(CH_GATED[2]));
    tick();
    expect_val("ch2_wcnt", 32'h1); check(32'(dut.g_ch[2].wake_cnt_q));
    CH_ENABLE = 4'b0011;
    tick();
    expect_val("ch2_off",   32'(StOff)); check(32'(dut.g_ch[2].state_q));
    expect_val("ch2_gated", 32'h1);      check(32'(CH_GATED[2]));
    expect_val("ch2_ack",   32'h0);      check(32'(CH_WAKE_ACK[2]));
    expect_val("ch2_last",  32'h1);      check(32'(GCLK[2]));
    tick();
    expect_val("ch2_stop",  32'h0);      check(32'(GCLK[2]));

    // Auto-gating disabled, then limit lowered below saturated counters
    IDLE_LIMIT = 8'd0;
    CH_ENABLE  = 4'b1111;
    CH_ACTIVE  = 4'b1111;
    tick();
    expect_val("all_wake", 32'h0); check(32'(CH_GATED));
    CH_ACTIVE = 4'b0000;
    tick(2);
    ok = 1'b1;
    repeat (300) begin
      tick();
      if (CH_GATED !== 4'b0000) ok = 1'b0;
    end
    expect_val("limit0_hold", 32'h1);  check(32'(ok));
    expect_val("idle_sat3",   32'hFF); check(32'(dut.g_ch[3].idle_cnt_q));
    IDLE_LIMIT = 8'd5;
    tick();
    expect_val("limit5_gate", 32'hF);  check(32'(CH_GATED));

    // TESTMODE with every channel OFF
    CH_ENABLE = 4'b0000;
    tick();
    TESTMODE = 1'b1;
    tick(2);
    expect_val("tm_gclk_hi", 32'hF); check(32'(GCLK));
    @(negedge HCLK);
    #1;
    expect_val("tm_gclk_lo", 32'h0); check(32'(GCLK));
    expect_val("tm_gated",   32'hF); check(32'(CH_GATED));
    TESTMODE = 1'b0;

    // Async reset while channel 0 is running with an acknowledged request
    CH_ENABLE   = 4'b0001;
    CH_WAKE_REQ = 4'b0001;
    tick(4);
    expect_val("pre_rst_ack", 32'b0001); check(32'(CH_WAKE_ACK));
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    expect_val("async_ack",   32'h0); check(32'(CH_WAKE_ACK));
    expect_val("async_gated", 32'hF); check(32'(CH_GATED));
    @(negedge HCLK);
    #1;
    expect_val("async_gclk",  32'h0); check(32'(GCLK));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
